// File: rtl/cpu_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_loader_pkg
//  Purpose  : Shared types and constants for the CPU instruction-memory loader.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_loader_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LEN_LO = 3'd1,
      LEN_HI = 3'd2,
      DATA   = 3'd3,
      DONE   = 3'd4,
      ERR    = 3'd5
   } loader_state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int LEN_BYTES      = 2;

   function automatic logic is_loading(input loader_state_t s);
      return (s == LEN_LO) || (s == LEN_HI) || (s == DATA);
   endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_loader_packer.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_loader_packer
//  Purpose  : Packs bytes little-endian into 32-bit words, one-cycle word pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_loader_packer
   import cpu_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_clear,
   input  logic        i_valid,
   input  logic [7:0]  i_byte,
   output logic        o_last_lane,
   output logic        o_word_valid,
   output logic [31:0] o_word
);

   localparam int LANE_W = $clog2(BYTES_PER_WORD);
   localparam int BUF_W  = 8 * (BYTES_PER_WORD - 1);
   localparam logic [LANE_W-1:0] c_LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

   logic [LANE_W-1:0] r_lane;
   logic [BUF_W-1:0]  r_buf;
   logic [31:0]       r_word;
   logic              r_word_valid;

   assign o_last_lane  = (r_lane == c_LAST_LANE);
   assign o_word_valid = r_word_valid;
   assign o_word       = r_word;

   // Earlier bytes shift down so byte0 ends up in the least significant lane.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lane       <= '0;
         r_buf        <= '0;
         r_word       <= '0;
         r_word_valid <= 1'b0;
      end else begin
         r_word_valid <= 1'b0;
         if (i_clear) begin
            r_lane <= '0;
         end else if (i_valid) begin
            if (o_last_lane) begin
               r_word       <= {i_byte, r_buf};
               r_word_valid <= 1'b1;
            end else begin
               r_buf <= {i_byte, r_buf[BUF_W-1:8]};
            end
            r_lane <= r_lane + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/cpu_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_imem_loader
//  Purpose  : Loads CPU instruction memory from a length-prefixed host byte stream.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_imem_loader
   import cpu_loader_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int TIMEOUT_CYC = 1024
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [7:0]        i_rx_data,
   input  logic              i_rx_valid,
   output logic              o_rx_ready,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_waddr,
   output logic [31:0]       o_mem_wdata,
   output logic              o_cpu_hold,
   output logic              o_done,
   output logic              o_err
);

   localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [TMO_W-1:0]  c_TMO_LAST  = TMO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
   localparam logic [ADDR_W-1:0] c_ADDR_STEP = ADDR_W'(BYTES_PER_WORD);

   loader_state_t     r_state;
   loader_state_t     w_next;
   logic [7:0]        r_len_lo;
   logic [15:0]       r_rem;
   logic [TMO_W-1:0]  r_tmo;
   logic [ADDR_W-1:0] r_waddr;
   logic [ADDR_W-1:0] r_mem_waddr;
   logic [15:0]       w_len;
   logic              w_start;
   logic              w_accept;
   logic              w_timeout;
   logic              w_pack_in;
   logic              w_last_lane;

   assign w_start   = i_start && !is_loading(r_state);
   assign w_accept  = i_rx_valid && o_rx_ready;
   assign w_len     = {i_rx_data, r_len_lo};
   assign w_pack_in = w_accept && (r_state == DATA);
   assign w_timeout = (TIMEOUT_CYC != 0) && is_loading(r_state) && !w_accept
                      && (r_tmo == c_TMO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE, DONE, ERR: if (i_start) w_next = LEN_LO;
         LEN_LO:          if (w_accept) w_next = LEN_HI;
         LEN_HI: begin
            if (w_accept) begin
               if (w_len == 16'd0)           w_next = DONE;
               else if (w_len[1:0] != 2'b00) w_next = ERR;
               else                          w_next = DATA;
            end
         end
         DATA:            if (w_accept && (r_rem == 16'd1)) w_next = DONE;
         default:         w_next = IDLE;
      endcase
      if (w_timeout) w_next = ERR;
   end

   always_comb begin
      o_rx_ready = is_loading(r_state);
      o_done     = (r_state == DONE);
      o_err      = (r_state == ERR);
      o_cpu_hold = (r_state != DONE);
   end

   // The final word's write lands in the first DONE cycle; no backpressure exists.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_len_lo    <= '0;
         r_rem       <= '0;
         r_tmo       <= '0;
         r_waddr     <= '0;
         r_mem_waddr <= '0;
      end else begin
         if (w_start) begin
            r_tmo   <= '0;
            r_rem   <= '0;
            r_waddr <= '0;
         end else if (is_loading(r_state)) begin
            r_tmo <= w_accept ? '0 : r_tmo + 1'b1;
         end
         if (w_accept) begin
            case (r_state)
               LEN_LO:  r_len_lo <= i_rx_data;
               LEN_HI:  r_rem    <= w_len;
               DATA:    r_rem    <= r_rem - 16'd1;
               default: ;
            endcase
         end
         if (w_pack_in && w_last_lane) begin
            r_mem_waddr <= r_waddr;
            r_waddr     <= r_waddr + c_ADDR_STEP;
         end
      end
   end

   cpu_loader_packer u_packer (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_clear      (w_start),
      .i_valid      (w_pack_in),
      .i_byte       (i_rx_data),
      .o_last_lane  (w_last_lane),
      .o_word_valid (o_mem_we),
      .o_word       (o_mem_wdata)
   );

   assign o_mem_waddr = r_mem_waddr;

endmodule
`default_nettype wire

// File: tb/tb_cpu_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_imem_loader
//  Purpose  : Directed self-checking bench for cpu_imem_loader.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_imem_loader;
   import cpu_loader_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic [7:0]  i_rx_data = 8'h00;
   logic        i_rx_valid = 1'b0;
   logic        o_rx_ready;
   logic        o_mem_we;
   logic [15:0] o_mem_waddr;
   logic [31:0] o_mem_wdata;
   logic        o_cpu_hold;
   logic        o_done;
   logic        o_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [15:0] a;
      logic [31:0] d;
      int          c;
   } wr_t;
   wr_t wq[$];
   int  accq[$];

   cpu_imem_loader #(.ADDR_W(16), .TIMEOUT_CYC(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_start     (i_start),
      .i_rx_data   (i_rx_data),
      .i_rx_valid  (i_rx_valid),
      .o_rx_ready  (o_rx_ready),
      .o_mem_we    (o_mem_we),
      .o_mem_waddr (o_mem_waddr),
      .o_mem_wdata (o_mem_wdata),
      .o_cpu_hold  (o_cpu_hold),
      .o_done      (o_done),
      .o_err       (o_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (o_mem_we === 1'b1) wq.push_back('{o_mem_waddr, o_mem_wdata, cyc});
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      i_start = 1'b1;
      tick(1);
      i_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      i_rx_data  = b;
      i_rx_valid = 1'b1;
      while (!o_rx_ready && n < 50) begin
         tick(1);
         n++;
      end
      if (n >= 50) chk("rx_ready_wait", {63'd0, o_rx_ready}, 64'd1);
      tick(1);
      accq.push_back(cyc);
      i_rx_valid = 1'b0;
   endtask

   task automatic send_seq(input int n, input logic [127:0] v, input int gap);
      for (int i = 0; i < n; i++) begin
         tick(gap);
         send_byte(v[8*i +: 8]);
      end
   endtask

   task automatic chk_wr(input int idx, input logic [15:0] a, input logic [31:0] d);
      if (idx < wq.size()) begin
         chk("wr_addr", {48'd0, wq[idx].a}, {48'd0, a});
         chk("wr_data", {32'd0, wq[idx].d}, {32'd0, d});
      end else begin
         chk("wr_missing", 64'(wq.size()), 64'(idx + 1));
      end
   endtask

   initial begin
      int bad;
      // 1: reset and idle
      tick(3);
      chk("rst_hold",  {63'd0, o_cpu_hold}, 64'd1);
      chk("rst_ready", {63'd0, o_rx_ready}, 64'd0);
      chk("rst_waddr", {48'd0, o_mem_waddr}, 64'd0);
      chk("rst_wdata", {32'd0, o_mem_wdata}, 64'd0);
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         if (o_cpu_hold !== 1'b1 || o_rx_ready !== 1'b0 || o_mem_we !== 1'b0 ||
             o_done !== 1'b0 || o_err !== 1'b0) bad++;
      end
      chk("idle_100", 64'(bad), 64'd0);
      chk("idle_state", {61'd0, dut.r_state}, {61'd0, IDLE});

      // 2: 8-byte load
      wq.delete(); accq.delete();
      pulse_start();
      send_seq(10, 128'h88776655443322110008, 0);
      tick(1);
      chk("l8_nwr", 64'(wq.size()), 64'd2);
      chk_wr(0, 16'h0000, 32'h44332211);
      chk_wr(1, 16'h0004, 32'h88776655);
      if (wq.size() >= 2 && accq.size() >= 10) begin
         chk("l8_lat0", 64'(wq[0].c), 64'(accq[5] + 1));
         chk("l8_lat1", 64'(wq[1].c), 64'(accq[9] + 1));
      end
      chk("l8_done", {63'd0, o_done}, 64'd1);
      chk("l8_hold", {63'd0, o_cpu_hold}, 64'd0);
      chk("l8_err",  {63'd0, o_err}, 64'd0);

      // 3: bad length then zero length
      wq.delete();
      pulse_start();
      chk("st_hold", {63'd0, o_cpu_hold}, 64'd1);
      chk("st_done", {63'd0, o_done}, 64'd0);
      send_seq(2, 128'h0006, 0);
      chk("l6_err",  {63'd0, o_err}, 64'd1);
      chk("l6_hold", {63'd0, o_cpu_hold}, 64'd1);
      tick(3);
      chk("l6_sticky", {63'd0, o_err}, 64'd1);
      chk("l6_nwr", 64'(wq.size()), 64'd0);
      pulse_start();
      chk("l0_errclr", {63'd0, o_err}, 64'd0);
      send_seq(2, 128'h0000, 0);
      chk("l0_done", {63'd0, o_done}, 64'd1);
      chk("l0_hold", {63'd0, o_cpu_hold}, 64'd0);
      chk("l0_err",  {63'd0, o_err}, 64'd0);
      chk("l0_nwr", 64'(wq.size()), 64'd0);

      // 4: timeout after a partial word, then 15-cycle gaps
      wq.delete();
      pulse_start();
      send_seq(4, 128'hBBAA0008, 0);
      tick(15);
      chk("tmo_15", {63'd0, o_err}, 64'd0);
      tick(1);
      chk("tmo_16", {63'd0, o_err}, 64'd1);
      chk("tmo_hold", {63'd0, o_cpu_hold}, 64'd1);
      chk("tmo_nwr", 64'(wq.size()), 64'd0);
      wq.delete();
      pulse_start();
      send_seq(10, 128'h08070605040302010008, 15);
      tick(1);
      chk("gap_done", {63'd0, o_done}, 64'd1);
      chk("gap_err",  {63'd0, o_err}, 64'd0);
      chk("gap_nwr", 64'(wq.size()), 64'd2);
      chk_wr(0, 16'h0000, 32'h04030201);
      chk_wr(1, 16'h0004, 32'h08070605);

      // 5: reset mid-load
      wq.delete();
      pulse_start();
      send_seq(7, 128'h0504030201000C, 0);
      rst_n = 1'b0;
      #1;
      chk("mr_state", {61'd0, dut.r_state}, {61'd0, IDLE});
      chk("mr_hold",  {63'd0, o_cpu_hold}, 64'd1);
      chk("mr_ready", {63'd0, o_rx_ready}, 64'd0);
      chk("mr_we",    {63'd0, o_mem_we}, 64'd0);
      chk("mr_nwr", 64'(wq.size()), 64'd1);
      chk_wr(0, 16'h0000, 32'h04030201);
      tick(2);
      rst_n = 1'b1;
      i_rx_data  = 8'h5A;
      i_rx_valid = 1'b1;
      tick(30);
      i_rx_valid = 1'b0;
      chk("mr_post_nwr", 64'(wq.size()), 64'd1);
      chk("mr_post_hold", {63'd0, o_cpu_hold}, 64'd1);

      // 6: start ignored mid-DATA, then reload from DONE
      wq.delete();
      pulse_start();
      send_seq(5, 128'h3322110008, 0);
      pulse_start();
      chk("md_state", {61'd0, dut.r_state}, {61'd0, DATA});
      send_seq(5, 128'h8877665544, 0);
      tick(1);
      chk("md_nwr", 64'(wq.size()), 64'd2);
      chk_wr(0, 16'h0000, 32'h44332211);
      chk_wr(1, 16'h0004, 32'h88776655);
      chk("md_done", {63'd0, o_done}, 64'd1);
      wq.delete();
      i_start    = 1'b1;
      i_rx_valid = 1'b1;
      i_rx_data  = 8'h05;
      tick(1);
      i_start    = 1'b0;
      i_rx_valid = 1'b0;
      chk("rl_hold",  {63'd0, o_cpu_hold}, 64'd1);
      chk("rl_done",  {63'd0, o_done}, 64'd0);
      chk("rl_state", {61'd0, dut.r_state}, {61'd0, LEN_LO});
      send_seq(6, 128'hEFBEADDE0004, 0);
      tick(1);
      chk("rl_nwr", 64'(wq.size()), 64'd1);
      chk_wr(0, 16'h0000, 32'hEFBEADDE);
      chk("rl_done2", {63'd0, o_done}, 64'd1);
      chk("rl_hold2", {63'd0, o_cpu_hold}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
